// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game, including the seed exchange link
// used by both the seed frame transmitter and receiver.
package snake_pkg;

  typedef enum logic [1:0] {
    MENU,
    GAME,
    OVER
  } game_mode;

  localparam logic [7:0] SEED_HDR   = 8'hA5;
  localparam logic [4:0] SEED_X_RST = 5'd1;
  localparam logic [4:0] SEED_Y_RST = 5'd23;
  localparam logic [7:0] SEED_X_MAX = 8'd30;
  localparam logic [7:0] SEED_Y_MAX = 8'd23;

  typedef enum logic [1:0] {
    IDLE,
    GET_X,
    GET_Y,
    GET_CHK
  } seed_rx_state;

  // Checksum byte closing a seed frame.
  function automatic logic [7:0] seed_chk(input logic [7:0] x, input logic [7:0] y);
    return SEED_HDR ^ x ^ y;
  endfunction

endpackage

// File: rtl/seed_rx_timer.sv
// Inter-byte timeout counter for the seed frame receiver; saturates at CYCLES.
module seed_rx_timer #(
  parameter int unsigned CYCLES = 75_000
) (
  input  logic clk_75,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_75) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == W'(CYCLES));

endmodule

// File: rtl/seed_frame_rx.sv
// Seed frame receiver: decodes header/X/Y/checksum frames from the UART byte stream
// and holds the last accepted remote seed for the remote-start path.
module seed_frame_rx
  import snake_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 75_000
) (
  input  logic       clk_75,
  input  logic       rst,
  input  game_mode   mode,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] seed_x,
  output logic [4:0] seed_y,
  output logic       seed_valid,
  output logic       frame_err,
  output logic       busy
);

  seed_rx_state state_q, state_d;
  logic [7:0]   x_buf_q, x_buf_d;
  logic [7:0]   y_buf_q, y_buf_d;
  logic [4:0]   seed_x_q, seed_x_d;
  logic [4:0]   seed_y_q, seed_y_d;
  logic         seed_valid_q, seed_valid_d;
  logic         frame_err_q, frame_err_d;
  logic         expired;
  logic         frame_bad;

  seed_rx_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_75 (clk_75),
    .rst    (rst),
    .clear  ((state_q == IDLE) || rx_valid),
    .enable (state_q != IDLE),
    .expired(expired)
  );

  // Range check uses the full byte so out-of-range values never alias into 5 bits.
  assign frame_bad = (rx_data != seed_chk(x_buf_q, y_buf_q)) ||
                     (x_buf_q > SEED_X_MAX) || (y_buf_q > SEED_Y_MAX);

  always_comb begin
    state_d      = state_q;
    x_buf_d      = x_buf_q;
    y_buf_d      = y_buf_q;
    seed_x_d     = seed_x_q;
    seed_y_d     = seed_y_q;
    seed_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SEED_HDR)) begin
          state_d = GET_X;
        end
      end
      GET_X: begin
        if (rx_valid) begin
          x_buf_d = rx_data;
          state_d = GET_Y;
        end else if (expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      GET_Y: begin
        if (rx_valid) begin
          y_buf_d = rx_data;
          state_d = GET_CHK;
        end else if (expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      GET_CHK: begin
        if (rx_valid) begin
          state_d = IDLE;
          if (frame_bad) begin
            frame_err_d = 1'b1;
          end else if (mode != GAME) begin
            seed_x_d     = x_buf_q[4:0];
            seed_y_d     = y_buf_q[4:0];
            seed_valid_d = 1'b1;
          end
        end else if (expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_75) begin
    if (rst) begin
      state_q      <= IDLE;
      x_buf_q      <= '0;
      y_buf_q      <= '0;
      seed_x_q     <= SEED_X_RST;
      seed_y_q     <= SEED_Y_RST;
      seed_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_buf_q      <= x_buf_d;
      y_buf_q      <= y_buf_d;
      seed_x_q     <= seed_x_d;
      seed_y_q     <= seed_y_d;
      seed_valid_q <= seed_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign seed_x     = seed_x_q;
  assign seed_y     = seed_y_q;
  assign seed_valid = seed_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_seed_frame_rx.sv
// Directed bench for seed_frame_rx: table of whole frames plus hand-written corner sequences.
module tb_seed_frame_rx;
  import snake_pkg::*;

  localparam int unsigned TO = 16;

  logic       clk_75 = 1'b0;
  logic       rst;
  game_mode   mode;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] seed_x;
  logic [4:0] seed_y;
  logic       seed_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seed_frame_rx #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_75    (clk_75),
    .rst       (rst),
    .mode      (mode),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .seed_x    (seed_x),
    .seed_y    (seed_y),
    .seed_valid(seed_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_75 = ~clk_75;

  typedef struct {
    string      name;
    game_mode   m;
    logic [7:0] b0, b1, b2, b3;
    logic       ev, ee;
    logic [4:0] ex, ey;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // One strobe, then a quiet cycle; returns #1 after the edge that sampled the byte.
  task automatic send(input logic [7:0] b);
    @(posedge clk_75); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_75); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk_75); #1;
  endtask

  initial begin
    logic [7:0] b2b[8];
    bit seen;

    vecs[0] = '{"good_12_17",  MENU, 8'hA5, 8'h0C, 8'h11, 8'hB8, 1'b1, 1'b0, 5'd12, 5'd17};
    vecs[1] = '{"bad_chk",     MENU, 8'hA5, 8'h0C, 8'h11, 8'hB9, 1'b0, 1'b1, 5'd12, 5'd17};
    vecs[2] = '{"x_31",        MENU, 8'hA5, 8'h1F, 8'h02, 8'hB8, 1'b0, 1'b1, 5'd12, 5'd17};
    vecs[3] = '{"y_24",        MENU, 8'hA5, 8'h00, 8'h18, 8'hBD, 1'b0, 1'b1, 5'd12, 5'd17};
    vecs[4] = '{"x_21_alias",  MENU, 8'hA5, 8'h21, 8'h01, 8'h85, 1'b0, 1'b1, 5'd12, 5'd17};
    vecs[5] = '{"max_30_23",   MENU, 8'hA5, 8'h1E, 8'h17, 8'hAC, 1'b1, 1'b0, 5'd30, 5'd23};
    vecs[6] = '{"game_drop",   GAME, 8'hA5, 8'h07, 8'h08, 8'hAA, 1'b0, 1'b0, 5'd30, 5'd23};
    vecs[7] = '{"hdr_as_data", OVER, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b1, 5'd30, 5'd23};

    rst      = 1'b1;
    mode     = MENU;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) idle_cycle();
    rst = 1'b0;
    repeat (2) idle_cycle();
    check("rst_seed_x", 32'(seed_x), 32'd1);
    check("rst_seed_y", 32'(seed_y), 32'd23);
    check("rst_valid", 32'(seed_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      mode = vecs[i].m;
      send(vecs[i].b0);
      check({vecs[i].name, "_busy_mid"}, 32'(busy), 32'd1);
      send(vecs[i].b1);
      send(vecs[i].b2);
      send(vecs[i].b3);
      check({vecs[i].name, "_valid"}, 32'(seed_valid), 32'(vecs[i].ev));
      check({vecs[i].name, "_err"}, 32'(frame_err), 32'(vecs[i].ee));
      check({vecs[i].name, "_x"}, 32'(seed_x), 32'(vecs[i].ex));
      check({vecs[i].name, "_y"}, 32'(seed_y), 32'(vecs[i].ey));
      check({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
      idle_cycle();
      check({vecs[i].name, "_pulse_end"}, 32'(seed_valid | frame_err), 32'd0);
    end

    // Garbage before a header is dropped without an error.
    mode = MENU;
    send(8'h3C);
    check("garbage_err", 32'(frame_err), 32'd0);
    check("garbage_busy", 32'(busy), 32'd0);
    send(8'hA5); send(8'h05); send(8'h06); send(8'hA6);
    check("resync_valid", 32'(seed_valid), 32'd1);
    check("resync_xy", 32'({seed_x, seed_y}), 32'({5'd5, 5'd6}));

    // Timeout after two bytes, then recovery.
    send(8'hA5); send(8'h03);
    check("to_busy", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(TO) + 10 && !seen; i++) begin
      idle_cycle();
      if (frame_err) seen = 1'b1;
    end
    check("to_err", 32'(seen), 32'd1);
    check("to_busy_fall", 32'(busy), 32'd0);
    check("to_seed_held", 32'({seed_x, seed_y}), 32'({5'd5, 5'd6}));
    send(8'hA5); send(8'h0C); send(8'h11); send(8'hB8);
    check("to_recover", 32'({seed_valid, seed_x, seed_y}), 32'({1'b1, 5'd12, 5'd17}));

    // Slow but in-time bytes must not time out.
    send(8'hA5);
    repeat (TO - 3) idle_cycle();
    send(8'h05);
    repeat (TO - 3) idle_cycle();
    check("slow_no_err", 32'(frame_err), 32'd0);
    send(8'h06); send(8'hA6);
    check("slow_valid", 32'({seed_valid, seed_x, seed_y}), 32'({1'b1, 5'd5, 5'd6}));

    // Two frames back-to-back with no gap.
    b2b = '{8'hA5, 8'h0C, 8'h11, 8'hB8, 8'hA5, 8'h1E, 8'h17, 8'hAC};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_75); #1;
      if (i == 4) check("b2b_first", 32'({seed_valid, seed_x, seed_y}),
                        32'({1'b1, 5'd12, 5'd17}));
      rx_data  = b2b[i];
      rx_valid = 1'b1;
    end
    @(posedge clk_75); #1;
    rx_valid = 1'b0;
    check("b2b_second", 32'({seed_valid, seed_x, seed_y}), 32'({1'b1, 5'd30, 5'd23}));

    // Reset mid-frame aborts and restores seed reset values.
    mode = GAME;
    send(8'hA5); send(8'h07);
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    check("midrst_xy", 32'({seed_x, seed_y}), 32'({5'd1, 5'd23}));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pulses", 32'(seed_valid | frame_err), 32'd0);
    mode = MENU;
    send(8'hA5); send(8'h0C); send(8'h11); send(8'hB8);
    check("midrst_next", 32'({seed_valid, seed_x, seed_y}), 32'({1'b1, 5'd12, 5'd17}));

    idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk_75) begin
    if (!rst && seed_valid && frame_err) begin
      checks++;
      errors++;
      $display("FAIL pulse_excl actual 11 required not both");
    end
  end

endmodule

// File: doc/seed_frame_rx.md
# seed_frame_rx

Receive-side decoder for the seed exchange link between two boards. Consumes the byte stream from the UART receiver core, recognises 4-byte seed frames (header, seed X, seed Y, checksum), validates them, and holds the last good remote seed stable on `seed_x`/`seed_y` for the point generator's remote-start path. Counterpart of the seed frame transmitter fired by `seed_rdy`.

## Interface
- `TIMEOUT_CYCLES`, default 75_000: maximum `clk_75` cycles between consecutive bytes of one frame (1 ms).
- `clk_75`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  `game_mode`  current game mode (snake_pkg).
- `rx_data`  in  8  byte from UART receiver; valid only when `rx_valid`=1.
- `rx_valid`  in  1  single-cycle strobe per received byte.
- `seed_x`  out  5  last accepted remote seed X.
- `seed_y`  out  5  last accepted remote seed Y.
- `seed_valid`  out  1  one-cycle pulse: new seed accepted.
- `frame_err`  out  1  one-cycle pulse: frame rejected (checksum, range, timeout).
- `busy`  out  1  high while a frame is partially received.

## Operation
- Frame: byte0 = `SEED_HDR` (8'hA5), byte1 = X, byte2 = Y, byte3 = `SEED_HDR ^ X ^ Y`.
- FSM states: IDLE, GET_X, GET_Y, GET_CHK.
  - IDLE: on `rx_valid` with `rx_data`==A5 -> GET_X; any other byte is discarded silently (resync, no `frame_err`).
  - GET_X: on `rx_valid` latch byte into `x_buf` -> GET_Y. Any value, including A5, is data.
  - GET_Y: on `rx_valid` latch `y_buf` -> GET_CHK.
  - GET_CHK: on `rx_valid` -> IDLE; evaluate frame.
- Frame evaluation (GET_CHK byte):
  - checksum mismatch, or `x_buf` > 30, or `y_buf` > 23 -> `frame_err` pulse, outputs unchanged.
  - otherwise, if `mode`==GAME -> frame dropped silently (seed frozen during game), no pulses.
  - otherwise `seed_x`<=`x_buf[4:0]`, `seed_y`<=`y_buf[4:0]`, `seed_valid` pulse.
- Range check is on the full 8-bit byte (X=8'h21 fails even though low 5 bits are 1).
- Timeout: counter cleared on every accepted byte and in IDLE; increments in GET_X/GET_Y/GET_CHK; when it reaches `TIMEOUT_CYCLES` -> IDLE, `frame_err` pulse.
- `busy` = (state != IDLE).

## Timing
- Reset values: `seed_x`=1, `seed_y`=23 (match the generator's local seed reset), `seed_valid`=0, `frame_err`=0, `busy`=0, state IDLE, counter 0.
- `seed_x`/`seed_y`/`seed_valid` update on the edge after the cycle the checksum strobe is sampled (1-cycle latency); outputs registered, no combinational path from `rx_data`.
- `seed_x`/`seed_y` change only with `seed_valid`; otherwise held indefinitely.
- `rx_valid` on the same cycle the counter hits `TIMEOUT_CYCLES`: byte wins, timeout not taken.
- `seed_valid` and `frame_err` never both high.
- Back-to-back strobes on consecutive cycles fully supported; next frame's header accepted the cycle after GET_CHK.
- `rst` mid-frame: abort, all outputs and state to reset values next edge, partial buffers discarded.
- `mode` sampled only on the GET_CHK strobe cycle.

## Structure
- snake_pkg additions: `SEED_HDR`=8'hA5, `SEED_X_RST`=5'd1, `SEED_Y_RST`=5'd23, `SEED_X_MAX`=30, `SEED_Y_MAX`=23, state enum `seed_rx_state`; transmitter shares these.
- One sub-module: `seed_rx_timer` (clear/enable inputs, `expired` output, width `$clog2(TIMEOUT_CYCLES+1)`).

## Test plan
- Reset, no traffic -> `seed_x`=1, `seed_y`=23, pulses 0, `busy`=0.
- Mode MENU, bytes A5,0C,11,B8 -> `seed_valid` one cycle after last strobe, `seed_x`=12, `seed_y`=17.
- Bytes A5,0C,11,B9 -> `frame_err` pulse, seed unchanged; then 3C,A5,05,06,A6 -> garbage ignored, seed 5/6.
- Bytes A5,1F,02,B8 (X=31) -> `frame_err`; A5,00,18,BD (Y=24) -> `frame_err`.
- A5,03 then idle `TIMEOUT_CYCLES` cycles -> `frame_err`, `busy` falls; following valid frame accepted.
- Mode GAME, valid frame A5,07,08,AA -> no pulses, seed unchanged; `rst` asserted after A5,07 -> reset values, next frame decodes normally.
